// File: rtl/pixel_frame_sink.sv
// Stream sink at the end of the pixel pipeline: captures one frame into a local buffer with
// programmable backpressure and reports checksum/frame count. SINK_MINMAX_EN adds pix_min/pix_max.
module pixel_frame_sink #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cont,
  input  logic [7:0]        stall_mask,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [15:0]       checksum,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`ifdef SINK_MINMAX_EN
  ,
  output logic [DATA_W-1:0] pix_min,
  output logic [DATA_W-1:0] pix_max
`endif
);

  // state   | meaning
  // IDLE    | not capturing, ready low
  // CAPTURE | accepting pixels under the stall pattern
  // DONE    | one cycle: frame_done high, results latched
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_HEIGHT - 1);

  state_e              state_q, state_d;
  logic [2:0]          phase_q, phase_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [15:0]         sum_q, sum_d;
  logic [15:0]         checksum_q, checksum_d;
  logic [15:0]         count_q, count_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic                xfer;
  logic                last_pix;
  logic                abort;
  logic [ADDR_W-1:0]   wr_addr;

  assign xfer     = valid_in && ready_out;
  assign last_pix = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign abort    = (state_q == ST_CAPTURE) && !enable;
  assign wr_addr  = ADDR_W'(int'(row_q) * IMG_WIDTH + int'(col_q));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (enable) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!enable)              state_d = ST_IDLE;
        else if (xfer && last_pix) state_d = ST_DONE;
      end
      ST_DONE:    state_d = (cont && enable) ? ST_CAPTURE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_out  = (state_q == ST_CAPTURE) && !stall_mask[phase_q];
    frame_done = (state_q == ST_DONE);
  end

  always_comb begin
    phase_d    = (state_q == ST_CAPTURE && state_d == ST_CAPTURE) ? phase_q + 3'd1 : 3'd0;
    row_d      = row_q;
    col_d      = col_q;
    sum_d      = sum_q;
    checksum_d = checksum_q;
    count_d    = count_q;
    if (abort) begin
      row_d = '0;
      col_d = '0;
      sum_d = '0;
    end else if (xfer) begin
      sum_d = sum_q + 16'(pixel_in);
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + ADDR_W'(1);
      end else begin
        col_d = col_q + ADDR_W'(1);
      end
    end
    if (state_q == ST_DONE) begin
      checksum_d = sum_q;
      count_d    = count_q + 16'd1;
      sum_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      sum_q      <= '0;
      checksum_q <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      phase_q    <= phase_d;
      row_q      <= row_d;
      col_q      <= col_d;
      sum_q      <= sum_d;
      checksum_q <= checksum_d;
      count_q    <= count_d;
      rd_data_q  <= mem_q[rd_addr];
    end
  end

  // Frame buffer is deliberately left out of reset so a frame survives for readback.
  always_ff @(posedge clk) begin
    if (xfer) mem_q[wr_addr] <= pixel_in;
  end

  assign row         = row_q;
  assign col         = col_q;
  assign checksum    = checksum_q;
  assign frame_count = count_q;
  assign rd_data     = rd_data_q;

`ifdef SINK_MINMAX_EN
  logic [DATA_W-1:0] run_min_q, run_min_d;
  logic [DATA_W-1:0] run_max_q, run_max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;

  always_comb begin
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    min_d     = min_q;
    max_d     = max_q;
    if (abort) begin
      run_min_d = '1;
      run_max_d = '0;
    end else if (xfer) begin
      if (pixel_in < run_min_q) run_min_d = pixel_in;
      if (pixel_in > run_max_q) run_max_d = pixel_in;
    end
    if (state_q == ST_DONE) begin
      min_d     = run_min_q;
      max_d     = run_max_q;
      run_min_d = '1;
      run_max_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min_q <= '1;
      run_max_q <= '0;
      min_q     <= '1;
      max_q     <= '0;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  assign pix_min = min_q;
  assign pix_max = max_q;
`endif

endmodule

// File: tb/tb_pixel_frame_sink.sv
// Directed bench for pixel_frame_sink: capture, backpressure, continuous mode, abort, reset, readback.
module tb_pixel_frame_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cont = 1'b0;
  logic [7:0]  stall_mask = 8'h00;
  logic [7:0]  pixel_in = 8'h00;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [15:0] checksum;
  logic [9:0]  row;
  logic [9:0]  col;
  logic [9:0]  rd_addr = 10'd0;
  logic [7:0]  rd_data;
`ifdef SINK_MINMAX_EN
  logic [7:0]  pix_min;
  logic [7:0]  pix_max;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int last_done_xfer = 0;
  int prev_done_xfer = 0;

  pixel_frame_sink dut (
    .clk(clk), .rst(rst), .enable(enable), .cont(cont), .stall_mask(stall_mask),
    .pixel_in(pixel_in), .valid_in(valid_in), .ready_out(ready_out),
    .frame_done(frame_done), .frame_count(frame_count), .checksum(checksum),
    .row(row), .col(col), .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef SINK_MINMAX_EN
    , .pix_min(pix_min), .pix_max(pix_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    if (frame_done === 1'b1) begin
      prev_done_xfer = last_done_xfer;
      last_done_xfer = xfer_cnt;
      done_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; valid_in = 1'b0; cont = 1'b0; stall_mask = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // mode 0: idx[7:0], mode 1: constant, mode 2: 0x07..0xF3 ramp
  task automatic feed(input int n, input int mode, input logic [7:0] cval);
    int idx = 0;
    int cyc = 0;
    int budget = n * 4 + 64;
    while (idx < n && cyc < budget) begin
      tick();
      cyc++;
      case (mode)
        0:       pixel_in = 8'(idx);
        1:       pixel_in = cval;
        default: pixel_in = 8'(7 + idx % 237);
      endcase
      valid_in = 1'b1;
      if (ready_out === 1'b1) begin
        idx++;
        xfer_cnt++;
      end
    end
    tests_run++;
    if (idx !== n) begin
      tests_failed++;
      $display("FAIL feed_timeout: accepted %0d, required %0d", idx, n);
    end
  endtask

  task automatic stop();
    tick();
    valid_in = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests_run++;
    if ({ready_out, frame_done} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_ctl: got %b, required 00", {ready_out, frame_done});
    end
    tests_run++;
    if ({frame_count, checksum} !== 32'h0) begin
      tests_failed++; $display("FAIL reset_cnt: count %h sum %h, required 0", frame_count, checksum);
    end
    tests_run++;
    if ({row, col, rd_data} !== 28'h0) begin
      tests_failed++; $display("FAIL reset_pos: row %0d col %0d rd %h, required 0", row, col, rd_data);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (ready_out !== 1'b0) begin
      tests_failed++; $display("FAIL idle_ready: got %b, required 0", ready_out);
    end
  endtask

  task automatic test_single_frame();
    int d0;
    do_reset();
    d0 = done_cnt;
    enable = 1'b1;
    feed(1024, 0, 8'h00);
    stop();
    tests_run++;
    if (done_cnt - d0 !== 1) begin
      tests_failed++; $display("FAIL single_pulses: got %0d, required 1", done_cnt - d0);
    end
    // 4 * (0+..+255) = 130560 = 0x1FE00 -> 0xFE00 after 16-bit wrap
    tests_run++;
    if (checksum !== 16'hFE00) begin
      tests_failed++; $display("FAIL single_checksum: got %h, required FE00", checksum);
    end
    tests_run++;
    if (frame_count !== 16'd1) begin
      tests_failed++; $display("FAIL single_count: got %0d, required 1", frame_count);
    end
    tests_run++;
    if ({ready_out, row, col} !== 21'h0) begin
      tests_failed++; $display("FAIL single_idle: ready %b row %0d col %0d, required 0", ready_out, row, col);
    end
  endtask

  task automatic test_stall_pattern();
    do_reset();
    stall_mask = 8'b1010_1010;
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests_run++;
      if (ready_out !== ((k % 2) == 0)) begin
        tests_failed++; $display("FAIL stall_phase%0d: got %b, required %b", k, ready_out, (k % 2) == 0);
      end
    end
    feed(1024, 0, 8'h00);
    stop();
    tests_run++;
    if (checksum !== 16'hFE00) begin
      tests_failed++; $display("FAIL stall_checksum: got %h, required FE00", checksum);
    end
    rd_addr = 10'd5;
    tick();
    rd_addr = 10'd700;
    tests_run++;
    if (rd_data !== 8'h05) begin
      tests_failed++; $display("FAIL rd_latency: got %h, required 05", rd_data);
    end
    tick();
    tests_run++;
    if (rd_data !== 8'hBC) begin
      tests_failed++; $display("FAIL rd_700: got %h, required BC", rd_data);
    end
    stall_mask = 8'h00;
  endtask

  task automatic test_full_stall();
    do_reset();
    stall_mask = 8'hFF;
    enable = 1'b1;
    valid_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      tests_run++;
      if (ready_out !== 1'b0) begin
        tests_failed++; $display("FAIL full_stall%0d: got %b, required 0", k, ready_out);
      end
    end
    stop();
    stall_mask = 8'h00;
  endtask

  task automatic test_back_to_back();
    int d0;
    do_reset();
    d0 = done_cnt;
    cont = 1'b1;
    enable = 1'b1;
    feed(2048, 1, 8'h01);
    stop();
    cont = 1'b0;
    tests_run++;
    if (done_cnt - d0 !== 2) begin
      tests_failed++; $display("FAIL b2b_pulses: got %0d, required 2", done_cnt - d0);
    end
    tests_run++;
    if (last_done_xfer - prev_done_xfer !== 1024) begin
      tests_failed++; $display("FAIL b2b_spacing: got %0d, required 1024", last_done_xfer - prev_done_xfer);
    end
    tests_run++;
    if (checksum !== 16'h0400 || frame_count !== 16'd2) begin
      tests_failed++; $display("FAIL b2b_result: sum %h count %0d, required 0400/2", checksum, frame_count);
    end
  endtask

  task automatic test_abort();
    int d0;
    do_reset();
    enable = 1'b1;
    feed(1024, 1, 8'h01);
    stop();
    d0 = done_cnt;
    enable = 1'b1;
    feed(300, 1, 8'h05);
    tick();
    tests_run++;
    if (row !== 10'd9 || col !== 10'd12) begin
      tests_failed++; $display("FAIL abort_pos: row %0d col %0d, required 9/12", row, col);
    end
    enable = 1'b0;
    valid_in = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (done_cnt !== d0 || checksum !== 16'h0400 || frame_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL abort_hold: pulses %0d sum %h count %0d, required 0/0400/1", done_cnt - d0, checksum, frame_count);
    end
    tests_run++;
    if (row !== 10'd0 || col !== 10'd0) begin
      tests_failed++; $display("FAIL abort_clear: row %0d col %0d, required 0", row, col);
    end
    enable = 1'b1;
    feed(1024, 1, 8'h02);
    stop();
    tests_run++;
    if (checksum !== 16'h0800 || frame_count !== 16'd2 || done_cnt - d0 !== 1) begin
      tests_failed++;
      $display("FAIL abort_refill: sum %h count %0d pulses %0d, required 0800/2/1", checksum, frame_count, done_cnt - d0);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    enable = 1'b1;
    feed(1024, 1, 8'h03);
    stop();
    enable = 1'b1;
    feed(500, 0, 8'h00);
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (ready_out !== 1'b0 || row !== 10'd0 || col !== 10'd0) begin
      tests_failed++; $display("FAIL midrst_pos: ready %b row %0d col %0d, required 0", ready_out, row, col);
    end
    tests_run++;
    if (frame_count !== 16'd0 || checksum !== 16'd0) begin
      tests_failed++; $display("FAIL midrst_cnt: count %0d sum %h, required 0", frame_count, checksum);
    end
    rst = 1'b0;
    enable = 1'b0;
    valid_in = 1'b0;
    tick();
  endtask

`ifdef SINK_MINMAX_EN
  task automatic test_minmax();
    do_reset();
    tests_run++;
    if (pix_min !== 8'hFF || pix_max !== 8'h00) begin
      tests_failed++; $display("FAIL mm_reset: min %h max %h, required FF/00", pix_min, pix_max);
    end
    enable = 1'b1;
    feed(1024, 2, 8'h00);
    stop();
    tests_run++;
    if (pix_min !== 8'h07 || pix_max !== 8'hF3) begin
      tests_failed++; $display("FAIL mm_frame: min %h max %h, required 07/F3", pix_min, pix_max);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_stall_pattern();
    test_full_stall();
    test_back_to_back();
    test_abort();
    test_mid_reset();
`ifdef SINK_MINMAX_EN
    test_minmax();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
